rv_ctl_mc: RTL and testbench

Parametrised multicycle RISC-V control FSM for the shared multicycle datapath. It replaces the fixed-latency controller. Added capabilities:
- memory handshake with wait states and timeout;
- full RV32I branch set, I-type ALU ops, JALR, LUI and AUIPC;
- illegal-instruction and bus-error reporting.

It drives all datapath selects and strobes from instr and the ALU flags.

---
 rtl/rv_ctl_mc.sv | 208 ++++++++++++++++++++
 tb/tb_rv_ctl_mc.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rv_ctl_mc.sv
// rv_ctl_mc: multicycle RV32I control FSM with memory handshake, timeout and illegal/bus-error reporting
module rv_ctl_mc #(
  parameter int TIMEOUT_W     = 8,
  parameter int MAX_WAIT      = 255,
  parameter bit EN_ITYPE      = 1'b1,
  parameter bit EN_BRANCH_ALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        memrw,
  output logic [1:0]  pcsource,
  output logic        pcwrite,
  output logic        pccen,
  output logic        irwrite,
  output logic [1:0]  wbsel,
  output logic        regwen,
  output logic [2:0]  immsel,
  output logic [1:0]  asel,
  output logic [1:0]  bsel,
  output logic [3:0]  alusel,
  output logic        mdrwrite,
  output logic        illegal,
  output logic        bus_err,
  output logic        instret,
  output logic [3:0]  state_o
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_LW_MEM   = 4'd3,
    S_LW_WB    = 4'd4,
    S_SW_MEM   = 4'd5,
    S_ALU_R    = 4'd6,
    S_ALU_I    = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BR_EXEC  = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd15
  } state_t;
  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 bus_err_q, bus_err_d;
  logic [6:0]           op;
  logic [2:0]           f3;
  logic                 waiting, timeout, taken;
  logic                 unused_instr;
  assign op           = instr[6:0];
  assign f3           = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
  assign waiting      = (state_q == S_FETCH || state_q == S_LW_MEM || state_q == S_SW_MEM) && !mem_ready;
  assign timeout      = waiting && (MAX_WAIT != 0) && (cnt_q == TIMEOUT_W'(MAX_WAIT));
  assign taken        = f3[0] ^ (f3[2] ? (f3[1] ? ltu : lt) : zero);
  assign bus_err      = bus_err_q;
  assign state_o      = state_q;
  // state, wait counter and sticky bus error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  // next state and datapath controls; everything held at 0 while in reset
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    memrw     = 1'b0;
    pcsource  = 2'd0;
    pcwrite   = 1'b0;
    pccen     = 1'b0;
    irwrite   = 1'b0;
    wbsel     = 2'd0;
    regwen    = 1'b0;
    immsel    = 3'd0;
    asel      = 2'd0;
    bsel      = 2'd0;
    alusel    = 4'b0000;
    mdrwrite  = 1'b0;
    illegal   = 1'b0;
    instret   = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          irwrite = mem_ready;
          pccen   = mem_ready;
          pcwrite = mem_ready;
          state_d = mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
        end
        S_DECODE: begin
          asel    = 2'd1;
          bsel    = 2'd1;
          immsel  = 3'd2;
          state_d = S_FETCH;
          case (op)
            7'b0000011: if (f3 == 3'b010) state_d = S_MEM_ADDR;
            7'b0100011: if (f3 == 3'b010) state_d = S_MEM_ADDR;
            7'b0110011: state_d = S_ALU_R;
            7'b0010011: if (EN_ITYPE) state_d = S_ALU_I;
            7'b1100011: if (f3[2:1] != 2'b01 && (EN_BRANCH_ALL || f3 == 3'b000)) state_d = S_BR_EXEC;
            7'b1101111: state_d = S_JAL;
            7'b1100111: if (f3 == 3'b000) state_d = S_JALR;
            7'b0110111: state_d = S_LUI;
            7'b0010111: state_d = S_AUIPC;
            default:    state_d = S_FETCH;
          endcase
          illegal = state_d == S_FETCH;
        end
        S_MEM_ADDR: begin
          bsel    = 2'd1;
          immsel  = op[5] ? 3'd1 : 3'd0;
          state_d = op[5] ? S_SW_MEM : S_LW_MEM;
        end
        S_LW_MEM: begin
          mem_req  = 1'b1;
          mdrwrite = mem_ready;
          state_d  = mem_ready ? S_LW_WB : timeout ? S_TRAP : S_LW_MEM;
        end
        S_LW_WB: begin
          wbsel   = 2'd2;
          regwen  = 1'b1;
          instret = 1'b1;
          state_d = S_FETCH;
        end
        S_SW_MEM: begin
          mem_req = 1'b1;
          memrw   = 1'b1;
          instret = mem_ready;
          state_d = mem_ready ? S_FETCH : timeout ? S_TRAP : S_SW_MEM;
        end
        S_ALU_R: begin
          alusel  = {f3, instr[30]};
          state_d = S_ALU_WB;
        end
        S_ALU_I: begin
          bsel    = 2'd1;
          alusel  = {f3, (f3 == 3'b101) & instr[30]};
          state_d = S_ALU_WB;
        end
        S_ALU_WB: begin
          wbsel   = 2'd1;
          regwen  = 1'b1;
          instret = 1'b1;
          state_d = S_FETCH;
        end
        S_BR_EXEC: begin
          alusel   = 4'b0001;
          pcsource = 2'd1;
          pcwrite  = taken;
          instret  = 1'b1;
          state_d  = S_FETCH;
        end
        S_JAL: begin
          asel     = 2'd1;
          bsel     = 2'd1;
          immsel   = 3'd3;
          pcsource = 2'd1;
          pcwrite  = 1'b1;
          regwen   = 1'b1;
          instret  = 1'b1;
          state_d  = S_FETCH;
        end
        S_JALR: begin
          bsel     = 2'd1;
          pcsource = 2'd2;
          pcwrite  = 1'b1;
          regwen   = 1'b1;
          instret  = 1'b1;
          state_d  = S_FETCH;
        end
        S_LUI: begin
          immsel  = 3'd4;
          wbsel   = 2'd3;
          regwen  = 1'b1;
          instret = 1'b1;
          state_d = S_FETCH;
        end
        S_AUIPC: begin
          asel    = 2'd1;
          bsel    = 2'd1;
          immsel  = 3'd4;
          state_d = S_ALU_WB;
        end
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_FETCH;
      endcase
    end
  end
  // wait counter restarts on any state change or completed access; error latches on timeout
  always_comb begin
    cnt_d     = (waiting && state_d == state_q) ? cnt_q + 1'b1 : '0;
    bus_err_d = bus_err_q | timeout;
  end
endmodule

// File: tb/tb_rv_ctl_mc.sv
// tb_rv_ctl_mc: directed checks of the multicycle control FSM
module tb_rv_ctl_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero, lt, ltu, mem_ready;
  logic        mem_req, memrw, pcwrite, pccen, irwrite, regwen, mdrwrite, illegal, bus_err, instret;
  logic [1:0]  pcsource, wbsel, asel, bsel;
  logic [2:0]  immsel;
  logic [3:0]  alusel, state_o;
  logic        nb_mem_req, nb_memrw, nb_pcwrite, nb_pccen, nb_irwrite, nb_regwen, nb_mdrwrite, nb_illegal, nb_bus_err, nb_instret;
  logic [1:0]  nb_pcsource, nb_wbsel, nb_asel, nb_bsel;
  logic [2:0]  nb_immsel;
  logic [3:0]  nb_alusel, nb_state_o;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_ret = 0;
  int          in_sw;
  localparam logic [31:0] LW_I   = {12'd4, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] SW_I   = {7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011};
  localparam logic [31:0] BLT_I  = {7'd0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011};
  localparam logic [31:0] BGEU_I = {7'd0, 5'd2, 5'd1, 3'b111, 5'd0, 7'b1100011};
  localparam logic [31:0] SRAI_I = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd2, 7'b0010011};
  localparam logic [31:0] ADDI_I = {7'b0100000, 5'd3, 5'd1, 3'b000, 5'd2, 7'b0010011};
  localparam logic [31:0] JALR_I = {12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111};
  localparam logic [31:0] SYS_I  = 32'h0000_0073;
  rv_ctl_mc #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .memrw(memrw), .pcsource(pcsource), .pcwrite(pcwrite), .pccen(pccen),
    .irwrite(irwrite), .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel),
    .alusel(alusel), .mdrwrite(mdrwrite), .illegal(illegal), .bus_err(bus_err), .instret(instret),
    .state_o(state_o)
  );
  rv_ctl_mc #(.EN_BRANCH_ALL(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(nb_mem_req), .memrw(nb_memrw), .pcsource(nb_pcsource), .pcwrite(nb_pcwrite), .pccen(nb_pccen),
    .irwrite(nb_irwrite), .wbsel(nb_wbsel), .regwen(nb_regwen), .immsel(nb_immsel), .asel(nb_asel), .bsel(nb_bsel),
    .alusel(nb_alusel), .mdrwrite(nb_mdrwrite), .illegal(nb_illegal), .bus_err(nb_bus_err), .instret(nb_instret),
    .state_o(nb_state_o)
  );
  always #5 clk = ~clk;
  // retired-instruction counter for the main instance
  always @(negedge clk) if (rst && instret) n_ret++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
  endtask
  initial begin
    rst = 1'b0; instr = LW_I; zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
    step();
    chk("rst_state", state_o, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_irwrite", irwrite, 0);
    chk("rst_bus_err", bus_err, 0);
    rst = 1'b1;
    #1;
    chk("lw_fetch_state", state_o, 0);
    chk("lw_fetch_irwrite", {irwrite, pccen, pcwrite, pcsource}, 5'b11100);
    step();
    chk("lw_decode", {state_o, asel, bsel, immsel}, {4'd1, 2'd1, 2'd1, 3'd2});
    step();
    chk("lw_addr", {state_o, asel, bsel, immsel, alusel}, {4'd2, 2'd0, 2'd1, 3'd0, 4'd0});
    step();
    chk("lw_mem", {state_o, mem_req, memrw, mdrwrite}, {4'd3, 3'b101});
    step();
    chk("lw_wb", {state_o, wbsel, regwen, instret, mdrwrite}, {4'd4, 2'd2, 3'b110});
    step();
    chk("lw_done_state", state_o, 0);
    chk("lw_instret_cnt", n_ret, 1);
    instr = SW_I;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fwait_req", {state_o, mem_req, irwrite, pcwrite}, {4'd0, 3'b100});
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("fwait_done", {mem_req, irwrite, pcwrite}, 3'b111);
    step();
    chk("fwait_decode", {state_o, bus_err}, {4'd1, 1'b0});
    step();
    chk("sw_addr", {state_o, immsel, bsel}, {4'd2, 3'd1, 2'd1});
    mem_ready = 1'b0;
    step();
    chk("sw_mem", {state_o, mem_req, memrw, bus_err}, {4'd5, 3'b110});
    in_sw = 0;
    for (int i = 0; i < 20 && state_o != 4'd15; i++) begin
      in_sw++;
      step();
    end
    chk("tmo_cycles", in_sw, 5);
    chk("trap", {state_o, bus_err, mem_req, memrw, instret}, {4'd15, 4'b1000});
    step();
    chk("trap_sticky", {state_o, bus_err}, {4'd15, 1'b1});
    rst = 1'b0;
    #1;
    chk("trap_clear", {state_o, bus_err, mem_req}, {4'd0, 2'b00});
    instr = BLT_I; lt = 1'b1; mem_ready = 1'b1;
    do_reset();
    step();
    chk("blt_decode", {state_o, illegal}, {4'd1, 1'b0});
    chk("blt_nb_illegal", {nb_state_o, nb_illegal}, {4'd1, 1'b1});
    step();
    chk("blt_exec", {state_o, pcwrite, pcsource, alusel, instret}, {4'd9, 1'b1, 2'd1, 4'b0001, 1'b1});
    chk("blt_nb_fetch", nb_state_o, 0);
    step();
    instr = BGEU_I; ltu = 1'b1;
    step();
    step();
    chk("bgeu_exec", {state_o, pcwrite, pcsource}, {4'd9, 1'b0, 2'd1});
    step();
    instr = SRAI_I;
    step();
    step();
    chk("srai", {state_o, alusel, immsel, bsel}, {4'd7, 4'b1011, 3'd0, 2'd1});
    step();
    chk("srai_wb", {state_o, wbsel, regwen, instret}, {4'd8, 2'd1, 2'b11});
    step();
    instr = ADDI_I;
    step();
    step();
    chk("addi_b30", {state_o, alusel}, {4'd7, 4'b0000});
    step();
    step();
    instr = JALR_I;
    step();
    step();
    chk("jalr", {state_o, pcsource, pcwrite, regwen, wbsel, instret}, {4'd11, 2'd2, 2'b11, 2'd0, 1'b1});
    step();
    instr = SYS_I;
    n_ret = 0;
    step();
    chk("sys_decode", {state_o, illegal, regwen, instret}, {4'd1, 3'b100});
    step();
    chk("sys_fetch", {state_o, illegal}, {4'd0, 1'b0});
    chk("sys_no_ret", n_ret, 0);
    instr = LW_I;
    step();
    step();
    mem_ready = 1'b0;
    step();
    chk("abort_lwmem", state_o, 3);
    rst = 1'b0;
    #1;
    chk("abort_state", state_o, 0);
    chk("abort_strobes", {mem_req, mdrwrite, regwen, irwrite, pcwrite, instret}, 6'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
